// File: rtl/music_pkg.sv
// Shared constants for the melody player: note codes, tone half-periods, FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package music_pkg;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_END  = 4'd15;

  // Half-period in 100 MHz clock cycles, round(100e6 / (2*f)), equal temperament, A4 = 440 Hz.
  // Index is the note code: 1 = C4 ... 14 = C#5. Rest and END carry no tone.
  localparam logic [17:0] HALF_PERIOD [16] = '{
    18'd0,       // rest
    18'd191113,  // C4
    18'd180386,  // C#4
    18'd170262,  // D4
    18'd160706,  // D#4
    18'd151686,  // E4
    18'd143173,  // F4
    18'd135137,  // F#4
    18'd127553,  // G4
    18'd120394,  // G#4
    18'd113636,  // A4
    18'd107258,  // A#4
    18'd101238,  // B4
    18'd95556,   // C5
    18'd90193,   // C#5
    18'd0        // END marker
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_PLAY  = 2'd3
  } state_t;

endpackage

// File: rtl/tick_div.sv
// Duration tick generator: counts 0..TICK_DIV-1 and flags the last count as a tick.
// Latency: tick is combinational from the counter; restart takes effect on the next edge.
// Backpressure: none, free-running unless restarted.
module tick_div #(
  parameter int unsigned TICK_DIV = 1_562_500
) (
  input  logic clock,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  // Wrap at the last count; restart realigns the divider to a note boundary.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through a registered note ROM and drives tone half-period/enable; optional ARTIC_GAP_EN mutes the last tick of multi-tick notes.
// Latency: outputs valid 2 edges after start is sampled; notes are back-to-back with no dead cycles.
// Backpressure: none; stop aborts to IDLE on the next edge, start is ignored while busy.
module melody_sequencer
  import music_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1_562_500,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              busy,
  output logic              tone_en,
  output logic [3:0]        note_code,
  output logic [17:0]       half_period,
  output logic              done
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [3:0]        note_code_q, note_code_d;
  logic [17:0]       half_period_q, half_period_d;
  logic              tone_en_q, tone_en_d;
  logic [3:0]        dur_q, dur_d;
  logic [3:0]        tcnt_q, tcnt_d;
  logic              done_q, done_d;

  logic       tick;
  logic       restart;
  logic       gap;
  logic [3:0] rom_code;
  logic [3:0] rom_dur;
  logic       capture;
  logic       is_end;
  logic       end_loop;
  logic       abort;

  tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .clock   (clock),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  assign rom_code = rom_data[7:4];
  assign rom_dur  = rom_data[3:0];
  // rom_data always belongs to rom_addr_q here: LOAD follows a fetch of rom_addr_q,
  // and PLAY has already prefetched the incremented address.
  assign capture  = (state_q == ST_LOAD) ||
                    ((state_q == ST_PLAY) && tick && (tcnt_q == dur_q));
  assign is_end   = (rom_code == NOTE_END);
  // Looping on an END stored at address 0 would spin forever with no sound.
  assign end_loop = loop_en && (rom_addr_q != '0);
  assign abort    = stop && (state_q != ST_IDLE);

`ifdef ARTIC_GAP_EN
  assign gap = (state_q == ST_PLAY) && (dur_q != '0) && (tcnt_q == dur_q);
`else
  assign gap = 1'b0;
`endif

  assign rom_addr    = rom_addr_q;
  assign busy        = (state_q != ST_IDLE);
  assign tone_en     = tone_en_q & ~gap;
  assign note_code   = note_code_q;
  assign half_period = half_period_q;
  assign done        = done_q;

  // State and datapath registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rom_addr_q    <= '0;
      note_code_q   <= '0;
      half_period_q <= '0;
      tone_en_q     <= 1'b0;
      dur_q         <= '0;
      tcnt_q        <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rom_addr_q    <= rom_addr_d;
      note_code_q   <= note_code_d;
      half_period_q <= half_period_d;
      tone_en_q     <= tone_en_d;
      dur_q         <= dur_d;
      tcnt_q        <= tcnt_d;
      done_q        <= done_d;
    end
  end

  // Next-state: start in IDLE, fixed fetch wait, then capture-driven transitions; stop overrides.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && !stop) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD, ST_PLAY: begin
        if (capture) begin
          if (is_end) state_d = end_loop ? ST_FETCH : ST_IDLE;
          else        state_d = ST_PLAY;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Outputs/datapath: load a note on capture, count ticks while playing, clear on abort or end.
  always_comb begin
    rom_addr_d    = rom_addr_q;
    note_code_d   = note_code_q;
    half_period_d = half_period_q;
    tone_en_d     = tone_en_q;
    dur_d         = dur_q;
    tcnt_d        = tcnt_q;
    done_d        = 1'b0;
    restart       = (state_q == ST_IDLE);
    if (abort) begin
      note_code_d   = '0;
      half_period_d = '0;
      tone_en_d     = 1'b0;
      tcnt_d        = '0;
    end else if ((state_q == ST_IDLE) && start && !stop) begin
      rom_addr_d = '0;
    end else if (capture) begin
      if (is_end) begin
        if (end_loop) begin
          // Previous note keeps sounding through the refetch.
          rom_addr_d = '0;
        end else begin
          done_d        = 1'b1;
          note_code_d   = '0;
          half_period_d = '0;
          tone_en_d     = 1'b0;
          tcnt_d        = '0;
        end
      end else begin
        note_code_d   = rom_code;
        half_period_d = HALF_PERIOD[rom_code];
        tone_en_d     = (rom_code != NOTE_REST);
        dur_d         = rom_dur;
        tcnt_d        = '0;
        restart       = 1'b1;
        rom_addr_d    = rom_addr_q + ADDR_W'(1);
      end
    end else if ((state_q == ST_PLAY) && tick) begin
      tcnt_d = tcnt_q + 4'd1;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer with TICK_DIV = 4 and a registered ROM model.
// Latency: expected per-cycle records are queued at stimulus time and compared each falling edge.
// Backpressure: n/a.
module tb_melody_sequencer;

  typedef struct packed {
    logic        busy;
    logic        tone;
    logic [17:0] hp;
    logic [3:0]  code;
    logic [3:0]  addr;
    logic        done;
  } rec_t;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [3:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        busy;
  logic        tone_en;
  logic [3:0]  note_code;
  logic [17:0] half_period;
  logic        done;

  logic [7:0] rom [16];
  rec_t       sb_q [$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         last_addr = 0;

  always #5 clock = ~clock;

  always @(posedge clock) rom_data <= rom[rom_addr];

  melody_sequencer #(.TICK_DIV(4), .ADDR_W(4)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .busy        (busy),
    .tone_en     (tone_en),
    .note_code   (note_code),
    .half_period (half_period),
    .done        (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [17:0] hp_ref(input int code);
    case (code)
      1:       return 18'd191113;
      10:      return 18'd113636;
      default: return 18'd0;
    endcase
  endfunction

  function automatic rec_t mk(input logic b, input logic t, input logic [17:0] h,
                              input logic [3:0] c, input int a, input logic d);
    rec_t r;
    r.busy = b; r.tone = t; r.hp = h; r.code = c; r.addr = 4'(a); r.done = d;
    return r;
  endfunction

  // Compare every falling edge while expectations are pending.
  always @(negedge clock) begin
    if (sb_q.size() != 0) begin
      rec_t r;
      r = sb_q.pop_front();
      chk("busy",        32'(busy),        32'(r.busy));
      chk("tone_en",     32'(tone_en),     32'(r.tone));
      chk("half_period", 32'(half_period), 32'(r.hp));
      chk("note_code",   32'(note_code),   32'(r.code));
      chk("rom_addr",    32'(rom_addr),    32'(r.addr));
      chk("done",        32'(done),        32'(r.done));
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic drain();
    int g = 0;
    while (sb_q.size() != 0 && g < 2000) begin
      step();
      g++;
    end
    chk("drain_timeout", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic set_rom(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
    rom[0] = b0; rom[1] = b1; rom[2] = b2;
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(mk(1'b0, 1'b0, 18'd0, 4'd0, last_addr, 1'b0));
  endtask

  // Reference playback model: one record per cycle after the start edge, cut at max_cyc.
  task automatic gen(input int max_cyc);
    int   a = 0;
    int   n = 0;
    logic ct = 1'b0;
    logic [17:0] ch = '0;
    logic [3:0]  cc = '0;
    for (int i = 0; i < 2; i++) begin
      if (n >= max_cyc) return;
      sb_q.push_back(mk(1'b1, 1'b0, 18'd0, 4'd0, 0, 1'b0)); n++; last_addr = 0;
    end
    for (int guard = 0; guard < 64; guard++) begin
      int c = int'(rom[a][7:4]);
      int d = int'(rom[a][3:0]);
      if (c == 15) begin
        if (loop_en && a != 0) begin
          a = 0;
          for (int i = 0; i < 2; i++) begin
            if (n >= max_cyc) return;
            sb_q.push_back(mk(1'b1, ct, ch, cc, 0, 1'b0)); n++; last_addr = 0;
          end
        end else begin
          sb_q.push_back(mk(1'b0, 1'b0, 18'd0, 4'd0, a, 1'b1));
          sb_q.push_back(mk(1'b0, 1'b0, 18'd0, 4'd0, a, 1'b0));
          last_addr = a;
          return;
        end
      end else begin
        ct = (c != 0); ch = hp_ref(c); cc = 4'(c);
        for (int i = 0; i < 4 * (d + 1); i++) begin
          logic t = ct;
`ifdef ARTIC_GAP_EN
          if (c != 0 && d >= 1 && i >= 4 * d) t = 1'b0;
`endif
          if (n >= max_cyc) return;
          sb_q.push_back(mk(1'b1, t, ch, cc, (a + 1) & 15, 1'b0)); n++;
          last_addr = (a + 1) & 15;
        end
        a = (a + 1) & 15;
      end
    end
  endtask

  task automatic start_play(input int max_cyc);
    start = 1'b1;
    gen(max_cyc);
    step();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    set_rom(8'hF0, 8'hF0, 8'hF0);
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tone", 32'(tone_en), 32'd0);
    chk("rst_hp",   32'(half_period), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    push_idle(3);
    drain();

    // Basic play with a start pulse mid-melody that must be ignored.
    set_rom(8'hA0, 8'h12, 8'hF0);
    start_play(1000);
    for (int i = 0; i < 5; i++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    drain();

    // Rest note.
    set_rom(8'h03, 8'hF0, 8'hF0);
    start_play(1000);
    drain();

    // Loop, then stop during the refetch.
    set_rom(8'hA0, 8'hF0, 8'hF0);
    loop_en = 1'b1;
    start_play(14);
    drain();
    stop = 1'b1;
    push_idle(2);
    step();
    stop = 1'b0;
    drain();

    // END at address 0 with looping must still finish.
    set_rom(8'hF0, 8'hF0, 8'hF0);
    start_play(1000);
    drain();
    loop_en = 1'b0;

    // start and stop together in IDLE.
    start = 1'b1; stop = 1'b1;
    push_idle(3);
    step();
    start = 1'b0; stop = 1'b0;
    drain();

    // Multi-tick note (articulation gap when enabled).
    set_rom(8'h12, 8'hF0, 8'hF0);
    start_play(1000);
    drain();

    // Asynchronous reset mid-note.
    set_rom(8'hA0, 8'h12, 8'hF0);
    start_play(8);
    drain();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_tone", 32'(tone_en), 32'd0);
    chk("arst_hp",   32'(half_period), 32'd0);
    chk("arst_code", 32'(note_code), 32'd0);
    chk("arst_addr", 32'(rom_addr), 32'd0);
    #1;
    rst_n = 1'b1;
    last_addr = 0;
    push_idle(3);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
